// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : Opcodes, FSM state encoding and constants for the ADD/SUB sequencer
// Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_LDA  = 3'd3;
    localparam logic [2:0] OP_STA  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_CLRC = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_MUL  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int MUL_ITERS = 8;

endpackage
`default_nettype wire

// File: rtl/alu_seq_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_mul_iter
// Brief    : Shift-and-add multiply iteration state; the adder lives outside
// Revision : 1.0  initial release
// ============================================================================
module alu_seq_mul_iter
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [DATA_W-1:0] mcand_init,
    input  logic [DATA_W-1:0] mplier_init,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic [DATA_W-1:0] prod,
    output logic [DATA_W-1:0] mcand,
    output logic              last,
    output logic [DATA_W-1:0] prod_final,
    output logic              ovf_final
);

    localparam int CNT_W = $clog2(MUL_ITERS);

    logic [DATA_W-1:0] r_prod;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic              r_mhi;
    logic              w_add;

    assign w_add      = r_mplier[0];
    assign prod       = r_prod;
    assign mcand      = r_mcand;
    assign last       = (r_cnt == CNT_W'(MUL_ITERS - 1));
    // Values this iteration commits; the FSM also captures them on the last step.
    assign prod_final = w_add ? alu_result : r_prod;
    assign ovf_final  = r_ovf | (w_add & (alu_carry | r_mhi));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_mhi    <= 1'b0;
        end else if (start) begin
            r_prod   <= '0;
            r_mcand  <= mcand_init;
            r_mplier <= mplier_init;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_mhi    <= 1'b0;
        end else if (step) begin
            r_prod   <= prod_final;
            r_ovf    <= ovf_final;
            r_mcand  <= r_mcand << 1;
            r_mhi    <= r_mhi | r_mcand[DATA_W-1];
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Brief    : Multi-cycle sequencer owning acc/carry around an external add/sub unit
// Revision : 1.0  initial release
// ============================================================================
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RF_AW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [RF_AW-1:0]  cmd_addr,
    output logic [RF_AW-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              alu_op_select,
    output logic [DATA_W-1:0] alu_operand,
    output logic [DATA_W-1:0] alu_acc_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_op;
    logic [RF_AW-1:0]  r_addr;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic              r_carry;

    logic              w_accept;
    logic              w_mul_start;
    logic              w_mul_step;
    logic              w_mul_last;
    logic [DATA_W-1:0] w_prod;
    logic [DATA_W-1:0] w_mcand;
    logic [DATA_W-1:0] w_prod_final;
    logic              w_ovf_final;

    assign cmd_ready   = (r_state == ST_IDLE) && !rst;
    assign w_accept    = cmd_valid && cmd_ready;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign err         = done && (r_op == OP_RSVD);
    assign rf_raddr    = r_addr;
    assign rf_waddr    = r_addr;
    assign rf_wdata    = r_acc;
    assign rf_we       = (r_state == ST_EXEC) && (r_op == OP_STA) && !rst;
    assign acc         = r_acc;
    assign carry       = r_carry;
    assign w_mul_start = (r_state == ST_EXEC) && (r_op == OP_MUL);
    assign w_mul_step  = (r_state == ST_MUL);

    alu_seq_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul_iter (
        .clk         (clk),
        .rst         (rst),
        .start       (w_mul_start),
        .step        (w_mul_step),
        .mcand_init  (r_acc),
        .mplier_init (r_b),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry),
        .prod        (w_prod),
        .mcand       (w_mcand),
        .last        (w_mul_last),
        .prod_final  (w_prod_final),
        .ovf_final   (w_ovf_final)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        alu_op_select = 1'b0;
        alu_operand   = '0;
        alu_acc_in    = r_acc;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_READ;
            ST_READ: w_next = ST_EXEC;
            ST_EXEC: begin
                if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
                    alu_operand   = r_b;
                    alu_op_select = (r_op == OP_SUB);
                end
                w_next = (r_op == OP_MUL) ? ST_MUL : ST_DONE;
            end
            ST_MUL: begin
                alu_acc_in  = w_prod;
                alu_operand = w_mcand;
                if (w_mul_last) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Architectural state moves only on the EXEC edge or the final MUL edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= OP_NOP;
            r_addr  <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= cmd_op;
                r_addr <= cmd_addr;
            end
            if (r_state == ST_READ) begin
                r_b <= rf_rdata;
            end
            if (r_state == ST_EXEC) begin
                case (r_op)
                    OP_ADD, OP_SUB: begin
                        r_acc   <= alu_result;
                        r_carry <= alu_carry;
                    end
                    OP_LDA:  r_acc   <= r_b;
                    OP_CLRC: r_carry <= 1'b0;
                    OP_NOP:  ;
                    default: ;
                endcase
            end
            if ((r_state == ST_MUL) && w_mul_last) begin
                r_acc   <= w_prod_final;
                r_carry <= w_ovf_final;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Brief    : Directed scoreboard bench with register-file and adder models
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq_ctrl;

    localparam logic [2:0] C_NOP = 3'd0, C_ADD = 3'd1, C_SUB = 3'd2, C_LDA = 3'd3;
    localparam logic [2:0] C_STA = 3'd4, C_MUL = 3'd5, C_CLRC = 3'd6, C_RSVD = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_addr = 4'd0;
    logic [3:0] rf_raddr;
    logic [7:0] rf_rdata;
    logic       rf_we;
    logic [3:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       alu_op_select;
    logic [7:0] alu_operand;
    logic [7:0] alu_acc_in;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic [7:0] acc;
    logic       carry;
    logic       busy;
    logic       done;
    logic       err;

    typedef struct {
        logic [7:0] acc;
        logic       carry;
        logic       err;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] rf [16];
    int         tests = 0;
    int         fails = 0;
    int         we_cnt = 0;
    int         done_cnt = 0;
    logic [3:0] last_waddr = 4'd0;
    logic [7:0] last_wdata = 8'd0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.DATA_W(8), .RF_AW(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .rf_raddr      (rf_raddr),
        .rf_rdata      (rf_rdata),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .alu_op_select (alu_op_select),
        .alu_operand   (alu_operand),
        .alu_acc_in    (alu_acc_in),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .acc           (acc),
        .carry         (carry),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    // External adder: 9-bit add/sub, bit 8 is carry (ADD) or borrow (SUB).
    always_comb begin
        if (alu_op_select)
            {alu_carry, alu_result} = {1'b0, alu_acc_in} - {1'b0, alu_operand};
        else
            {alu_carry, alu_result} = {1'b0, alu_acc_in} + {1'b0, alu_operand};
    end

    assign rf_rdata = rf[rf_raddr];

    always @(posedge clk) begin
        if (rf_we) begin
            rf[rf_waddr] = rf_wdata;
            last_waddr   = rf_waddr;
            last_wdata   = rf_wdata;
            we_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] addr);
        int n = 0;
        @(negedge clk);
        cmd_op = op;
        cmd_addr = addr;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("ready_at_issue", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 30);
        lat = n;
        check("done_seen", done, 1);
    endtask

    task automatic compare_head(input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_nonempty", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check("acc", acc, e.acc);
            check("carry", carry, e.carry);
            check("err", err, e.err);
            check("latency", lat, e.lat);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [3:0] addr,
                           input logic [7:0] eacc, input logic ecarry,
                           input logic eerr, input int elat);
        int lat;
        sb.push_back('{acc: eacc, carry: ecarry, err: eerr, lat: elat});
        issue(op, addr);
        wait_done(lat);
        compare_head(lat);
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    initial begin
        int we0;
        int dn0;
        int lat;
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        rf[1] = 8'h80; rf[2] = 8'h05; rf[3] = 8'h07; rf[4] = 8'h11;
        rf[5] = 8'h0F; rf[6] = 8'h10; rf[10] = 8'h5A;

        #1;
        check("rst_ready", cmd_ready, 0);
        check("rst_acc", acc, 8'h00);
        check("rst_carry", carry, 0);
        check("rst_done", done, 0);
        check("rst_we", rf_we, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_cmd(C_LDA, 4'd1, 8'h80, 1'b0, 1'b0, 3);
        run_cmd(C_ADD, 4'd1, 8'h00, 1'b1, 1'b0, 3);

        run_cmd(C_LDA, 4'd2, 8'h05, 1'b1, 1'b0, 3);
        run_cmd(C_SUB, 4'd3, 8'hFE, 1'b1, 1'b0, 3);
        run_cmd(C_CLRC, 4'd0, 8'hFE, 1'b0, 1'b0, 3);

        run_cmd(C_LDA, 4'd5, 8'h0F, 1'b0, 1'b0, 3);
        run_cmd(C_MUL, 4'd4, 8'hFF, 1'b0, 1'b0, 11);
        run_cmd(C_LDA, 4'd6, 8'h10, 1'b0, 1'b0, 3);
        run_cmd(C_MUL, 4'd6, 8'h00, 1'b1, 1'b0, 11);
        run_cmd(C_NOP, 4'd0, 8'h00, 1'b1, 1'b0, 3);

        run_cmd(C_LDA, 4'd10, 8'h5A, 1'b1, 1'b0, 3);
        we0 = we_cnt;
        run_cmd(C_STA, 4'd9, 8'h5A, 1'b1, 1'b0, 3);
        check("sta_we_count", we_cnt - we0, 1);
        check("sta_waddr", last_waddr, 4'd9);
        check("sta_wdata", last_wdata, 8'h5A);
        check("sta_rf9", rf[9], 8'h5A);
        run_cmd(C_RSVD, 4'd0, 8'h5A, 1'b1, 1'b1, 3);

        // New commands held on cmd_valid while busy must be ignored.
        dn0 = done_cnt;
        sb.push_back('{acc: 8'h05, carry: 1'b1, err: 1'b0, lat: 3});
        @(negedge clk);
        cmd_op = C_LDA; cmd_addr = 4'd2; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_op = C_ADD; cmd_addr = 4'd1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            check("ready_while_busy", cmd_ready, 0);
        end while (!done && lat < 30);
        cmd_valid = 1'b0;
        check("done_seen_busy", done, 1);
        compare_head(lat);
        repeat (3) @(negedge clk);
        check("busy_acc_trace", acc, 8'h05);
        check("busy_done_count", done_cnt - dn0, 1);

        // Reset in the fifth cycle after a MUL accept.
        run_cmd(C_LDA, 4'd5, 8'h0F, 1'b1, 1'b0, 3);
        dn0 = done_cnt;
        issue(C_MUL, 4'd4);
        repeat (5) @(negedge clk);
        check("mul_busy_pre_rst", busy, 1);
        rst = 1'b1;
        #1;
        check("mulrst_busy", busy, 0);
        check("mulrst_acc", acc, 8'h00);
        check("mulrst_carry", carry, 0);
        check("mulrst_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("mulrst_no_done", done_cnt - dn0, 0);
        check("mulrst_acc_after", acc, 8'h00);

        // Reset during the STA EXEC cycle.
        run_cmd(C_LDA, 4'd10, 8'h5A, 1'b0, 1'b0, 3);
        we0 = we_cnt;
        dn0 = done_cnt;
        issue(C_STA, 4'd11);
        repeat (2) @(negedge clk);
        check("sta_we_pre_rst", rf_we, 1);
        rst = 1'b1;
        #1;
        check("starst_we", rf_we, 0);
        check("starst_acc", acc, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("starst_no_write", we_cnt - we0, 0);
        check("starst_rf11", rf[11], 8'h00);
        check("starst_no_done", done_cnt - dn0, 0);

        run_cmd(C_LDA, 4'd1, 8'h80, 1'b0, 1'b0, 3);
        run_cmd(C_ADD, 4'd2, 8'h85, 1'b0, 1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer for the 8-bit ADD/SUB datapath of the tiny processor.
- Accepts one arithmetic command at a time over a valid/ready handshake.
- Fetches the operand from the register file, drives the external add/sub unit, and owns the architectural accumulator and carry flag.
- Implements ADD, SUB, LDA, STA, CLRC and an 8-iteration shift-and-add MUL that reuses the same adder.

Parameters:
- DATA_W, 8, datapath width (fixed at 8; MUL iteration count equals DATA_W)
- RF_AW, 4, register-file address width (16 registers)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  opcode
- cmd_addr  in  RF_AW  register operand address
- rf_raddr  out  RF_AW  register-file read address (combinational read)
- rf_rdata  in  DATA_W  register-file read data
- rf_we  out  1  register-file write enable
- rf_waddr  out  RF_AW  write address
- rf_wdata  out  DATA_W  write data
- alu_op_select  out  1  0 = ADD, 1 = SUB, to adder
- alu_operand  out  DATA_W  adder operand
- alu_acc_in  out  DATA_W  adder accumulator input
- alu_result  in  DATA_W  adder result
- alu_carry  in  1  adder carry/borrow
- acc  out  DATA_W  accumulator
- carry  out  1  carry/borrow flag
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion strobe
- err  out  1  valid with done: illegal opcode

Behaviour:
- Reset (async, immediate):
  - state = IDLE; acc, carry, done, err = 0.
  - rf_we = 0 and cmd_ready = 0 while rst is high.
- Opcodes: NOP=0, ADD=1, SUB=2, LDA=3, STA=4, MUL=5, CLRC=6; 7 is illegal.
- Handshake:
  - cmd_ready = (state == IDLE) && !rst.
  - A command is accepted on the edge where cmd_valid && cmd_ready; op and addr are latched.
  - cmd_valid outside IDLE is ignored. The requester must hold the command until it is accepted.
- States:
  - IDLE -> READ on accept.
  - READ: rf_raddr = latched addr; B <= rf_rdata; -> EXEC.
  - EXEC:
    - ADD/SUB: alu_acc_in = acc, alu_operand = B, alu_op_select = (op == SUB); acc <= alu_result, carry <= alu_carry.
    - LDA: acc <= B; carry unchanged.
    - STA: rf_we = 1, rf_waddr = addr, rf_wdata = acc, for exactly this cycle.
    - CLRC: carry <= 0.
    - NOP and illegal: no state change; the err flag is set for illegal.
    - MUL: prod <= 0, mcand <= acc, mplier <= B, cnt <= 0, ovf <= 0; -> MUL. All other ops -> DONE.
  - MUL (8 cycles):
    - alu_acc_in = prod, alu_operand = mcand, alu_op_select = 0.
    - If mplier[0]: prod <= alu_result and ovf |= alu_carry | mhi, where mhi is a sticky flag marking that a 1 has been shifted out of mcand.
    - Every cycle: mcand <= mcand << 1 (mhi |= mcand[7]), mplier >>= 1, cnt++.
    - On cnt == 7: acc <= final prod, carry <= final ovf; -> DONE.
    - carry therefore equals (true 16-bit product > 255).
  - DONE: done = 1, err = 1 if the opcode was illegal; -> IDLE.
- Latency from the accept edge to the done cycle:
  - 3 cycles for non-MUL ops.
  - 11 cycles for MUL (fixed; no early exit, even for a zero multiplier).
- Throughput: the next command can be accepted in the cycle after done.
- Idle adder drive: alu_op_select = 0, alu_operand = 0, alu_acc_in = acc.
- acc and carry change only on the EXEC edge, or on the final MUL edge.
- Reset mid-operation:
  - Aborts immediately: no write, no done, acc and carry cleared.
  - A reset during the STA EXEC cycle suppresses rf_we.
- All adder arithmetic is modulo 2^8. The carry/borrow comes solely from alu_carry.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams (OP_NOP..OP_CLRC, OP_RSVD);
  - state encoding (ST_IDLE, ST_READ, ST_EXEC, ST_MUL, ST_DONE);
  - MUL_ITERS = 8.
- One sub-module, alu_seq_mul_iter, is natural. It holds the prod/mcand/mplier/cnt/ovf/mhi registers and exposes start, step, last, product and ovf. The FSM and the adder mux stay in the top module.

Test Plan:
- LDA r1 (0x80), then ADD r1 -> acc = 0x00, carry = 1; done 3 cycles after each accept.
- LDA r2 (0x05), then SUB r3 (0x07) -> acc = 0xFE, carry = 1. Then CLRC -> carry = 0, acc = 0xFE.
- acc = 0x0F, MUL r4 (0x11) -> acc = 0xFF, carry = 0, done exactly 11 cycles after accept. Repeat with acc = 0x10, r = 0x10 -> acc = 0x00, carry = 1.
- acc = 0x5A, STA r9 -> rf_we high for exactly one cycle with waddr = 9 and wdata = 0x5A. Then opcode 7 -> done with err = 1 and acc/carry unchanged.
- cmd_valid held high with new commands while busy -> cmd_ready = 0, and only the first command executes (checked by the acc trace).
- rst asserted mid-MUL (cycle 5) and mid-STA EXEC -> immediate IDLE, acc = 0, carry = 0, no rf_we pulse, no done. The next command executes normally.
